tone_envelope_synth: RTL

Downstream stage of the song-playback controller. Consumes its `key_on`/`key[3:0]` note stream and drives the board speaker pin. Output is a square-wave tone at the selected pitch, amplitude-shaped by an attack/sustain/release envelope applied through PWM gating, so note starts and stops do not click.

---
 rtl/tone_envelope_synth.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/tone_envelope_synth.sv
// tone_envelope_synth: pitched square wave, amplitude-shaped by PWM gating from an envelope FSM.
// Define TONE_ENVELOPE_EN for timed attack/release ramps; otherwise notes gate fully on/off at once.
module tone_envelope_synth #(
   parameter int CLK_HZ   = 100_000_000,
   parameter int VOL_BITS = 8,
   parameter int ENV_STEP = 50_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                key_on,
   input  logic [3:0]          key,
   output logic                speaker,
   output logic                busy,
   output logic [3:0]          note,
   output logic [VOL_BITS-1:0] vol
);

   // Note frequencies in centi-hertz (C4..D6); result is the half period rounded to the nearest cycle.
   function automatic longint half_period_of(input int k);
      longint f_c;
      case (k)
         0:       f_c = 26163;
         1:       f_c = 29366;
         2:       f_c = 32963;
         3:       f_c = 34923;
         4:       f_c = 39200;
         5:       f_c = 44000;
         6:       f_c = 49388;
         7:       f_c = 52325;
         8:       f_c = 58733;
         9:       f_c = 65925;
         10:      f_c = 69846;
         11:      f_c = 78399;
         12:      f_c = 88000;
         13:      f_c = 98777;
         14:      f_c = 104650;
         default: f_c = 117466;
      endcase
      return (longint'(CLK_HZ) * 100 + f_c) / (2 * f_c);
   endfunction

   localparam int                  HP_W    = $clog2(half_period_of(0) + 1);
   localparam logic [VOL_BITS-1:0] VOL_MAX = {VOL_BITS{1'b1}};

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ATTACK  = 2'd1;
   localparam logic [1:0] S_SUSTAIN = 2'd2;
   localparam logic [1:0] S_RELEASE = 2'd3;

   logic [1:0]          state_q, state_d;
   logic [3:0]          note_q, note_d;
   logic [VOL_BITS-1:0] vol_q, vol_d;
   logic [HP_W-1:0]     tone_cnt_q, tone_cnt_d;
   logic                tone_q, tone_d;
   logic [VOL_BITS-1:0] pwm_cnt_q;
   logic                key_on_prev_q;
   logic                speaker_q;
   logic                key_rise, restart, env_step, tone_wrap;
   logic [HP_W-1:0]     half_last [16];

   for (genvar g = 0; g < 16; g++) begin : g_note_tbl
      assign half_last[g] = HP_W'(half_period_of(g) - 1);
   end

   assign key_rise = key_on & ~key_on_prev_q;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      state_d = state_q;
      note_d  = note_q;
      vol_d   = vol_q;
      restart = 1'b0;
      case (state_q)
         S_IDLE: restart = key_rise;
         S_ATTACK, S_SUSTAIN: begin
            if (!key_on) begin
`ifdef TONE_ENVELOPE_EN
               state_d = S_RELEASE;
`else
               state_d = S_IDLE;
               vol_d   = '0;
`endif
            end else if (key != note_q) begin
               restart = 1'b1;
            end else if (state_q == S_ATTACK) begin
               if (vol_q == VOL_MAX) state_d = S_SUSTAIN;
               else if (env_step)    vol_d   = vol_q + 1'b1;
            end
         end
         default: begin
            if (key_rise)          restart = 1'b1;
            else if (vol_q == '0)  state_d = S_IDLE;
            else if (env_step)     vol_d   = vol_q - 1'b1;
         end
      endcase
      // A (re)start outranks any step that falls in the same cycle.
      if (restart) begin
         state_d = S_ATTACK;
         note_d  = key;
`ifndef TONE_ENVELOPE_EN
         vol_d   = VOL_MAX;
`endif
      end
   end

   always_comb begin
      tone_wrap  = (tone_cnt_q == half_last[note_q]);
      tone_cnt_d = tone_wrap ? '0 : tone_cnt_q + 1'b1;
      tone_d     = tone_q ^ tone_wrap;
      if (restart) begin
         tone_cnt_d = '0;
         tone_d     = 1'b0;
      end
   end

`ifdef TONE_ENVELOPE_EN
   localparam int ENV_W = $clog2(ENV_STEP + 1);
   logic [ENV_W-1:0] env_cnt_q;

   assign env_step = (env_cnt_q == ENV_W'(ENV_STEP - 1));

   // Every state entry (including a restart into ATTACK) begins a fresh step interval.
   always_ff @(posedge clk) begin
      if (!rst)                                        env_cnt_q <= '0;
      else if (restart || state_d != state_q || env_step) env_cnt_q <= '0;
      else                                             env_cnt_q <= env_cnt_q + 1'b1;
   end
`else
   // No ramp timer: the step strobe is a constant that never fires.
   assign env_step = (ENV_STEP < 0);
`endif

   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      if (!rst) begin
         state_q       <= S_IDLE;
         note_q        <= '0;
         vol_q         <= '0;
         tone_cnt_q    <= '0;
         tone_q        <= 1'b0;
         pwm_cnt_q     <= '0;
         key_on_prev_q <= 1'b0;
         speaker_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         note_q        <= note_d;
         vol_q         <= vol_d;
         tone_cnt_q    <= tone_cnt_d;
         tone_q        <= tone_d;
         pwm_cnt_q     <= pwm_cnt_q + 1'b1;
         key_on_prev_q <= key_on;
         speaker_q     <= tone_q & (pwm_cnt_q < vol_q);
      end
   end

   assign speaker = speaker_q;
   assign busy    = (state_q != S_IDLE);
   assign note    = note_q;
   assign vol     = vol_q;

endmodule
